// File: rtl/sync_fifo_stream_reader_if.sv
// Handshake bundle between a synchronous FIFO read port, the stream reader
// and the downstream valid/ready consumer.
// The master modport is the reader. It issues FIFO reads and drives the stream.
// The slave modport is the FIFO plus consumer side.
interface sync_fifo_stream_reader_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_rd_data_i;
  logic                  fifo_read_o;
  logic                  flush_i;
  logic                  m_valid_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_ready_i;

  modport master (
    input  fifo_empty_i, fifo_rd_data_i, flush_i, m_ready_i,
    output fifo_read_o, m_valid_o, m_data_o
  );

  modport slave (
    output fifo_empty_i, fifo_rd_data_i, flush_i, m_ready_i,
    input  fifo_read_o, m_valid_o, m_data_o
  );
endinterface

// File: rtl/sync_fifo_stream_reader.sv
// Stream reader: prefetches words from a synchronous FIFO into a 2-entry
// buffer and presents them as a registered valid/ready stream at 1 word/cycle.
// FWFT=1 means FIFO read data is valid in the same cycle as the read.
// FWFT=0 means FIFO read data returns one cycle after the read.
// Optional macro SYNC_FIFO_STREAM_READER_STATS_EN adds two outputs:
// xfer_cnt_o counts pops and wraps.
// stall_cnt_o counts stall cycles and saturates.
module sync_fifo_stream_reader #(
  parameter int DATA_WIDTH = 32,
  parameter bit FWFT       = 1'b1
) (
  input  logic clk_i,
  input  logic rst_i,
  sync_fifo_stream_reader_if.master bus
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
  ,
  output logic [31:0] xfer_cnt_o,
  output logic [31:0] stall_cnt_o
`endif
);

  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} buf_state_e;

  buf_state_e            state, state_nxt;
  logic [DATA_WIDTH-1:0] head, tail;
  logic                  inflight;
  logic                  valid, pop, rd, cap;
  logic                  load_head, load_tail, shift;
  logic [2:0]            occ;

  // Valid is forced low during reset so no pop is accepted in a reset cycle.
  assign valid         = (state != EMPTY) && !rst_i;
  assign pop           = valid && bus.m_ready_i;
  assign bus.m_valid_o = valid;
  assign bus.m_data_o  = head;

  // Credit is buffered entries plus a read whose data has not yet returned.
  // A pop this cycle frees one slot, so that slot can be refilled right away.
  assign occ = {1'b0, state} + {2'b00, inflight};
  assign rd  = !bus.fifo_empty_i && !bus.flush_i && !rst_i &&
               ((occ - {2'b00, pop}) < 3'd2);
  assign bus.fifo_read_o = rd;

  // In FWFT mode the data is captured on the read edge.
  // In standard mode it is captured one edge later.
  assign cap = FWFT ? rd : inflight;

  // Next buffer occupancy and data movement.
  always_comb begin
    state_nxt = state;
    load_head = 1'b0;
    load_tail = 1'b0;
    shift     = 1'b0;
    if (bus.flush_i) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (cap) begin
          load_head = 1'b1;
          state_nxt = ONE;
        end
        ONE: begin
          if (cap && pop) begin
            load_head = 1'b1;
          end else if (cap) begin
            load_tail = 1'b1;
            state_nxt = TWO;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        TWO: if (pop) begin
          shift = 1'b1;
          if (cap) load_tail = 1'b1;
          else     state_nxt = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Buffer occupancy register.
  always_ff @(posedge clk_i) begin
    if (rst_i) state <= EMPTY;
    else       state <= state_nxt;
  end

  // Clearing inflight on flush drops the word still returning from the FIFO.
  always_ff @(posedge clk_i) begin
    if (rst_i || bus.flush_i) inflight <= 1'b0;
    else                      inflight <= FWFT ? 1'b0 : rd;
  end

  // Head drives the stream. Tail is the skid slot.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (load_head)  head <= bus.fifo_rd_data_i;
      else if (shift) head <= tail;
      if (load_tail)  tail <= bus.fifo_rd_data_i;
    end
  end

`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
  // Transfer counter wraps, stall counter saturates; flush leaves both alone.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      xfer_cnt_o  <= '0;
      stall_cnt_o <= '0;
    end else begin
      if (pop) xfer_cnt_o <= xfer_cnt_o + 32'd1;
      if (valid && !bus.m_ready_i && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Bench for sync_fifo_stream_reader. Two instances run side by side.
// Instance a uses FWFT=1 and instance b uses FWFT=0, each fed by its own FIFO model.
// Expected words go into per-instance queues at stimulus time.
// A monitor pops those queues on every accepted transfer.
module tb_sync_fifo_stream_reader;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sync_fifo_stream_reader_if #(.DATA_WIDTH(32)) ifa ();
  sync_fifo_stream_reader_if #(.DATA_WIDTH(32)) ifb ();

`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
  logic [31:0] xa, sa, xb, sb;
`endif

  sync_fifo_stream_reader #(.DATA_WIDTH(32), .FWFT(1'b1)) u_a (
    .clk_i(clk), .rst_i(rst), .bus(ifa.master)
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
    , .xfer_cnt_o(xa), .stall_cnt_o(sa)
`endif
  );

  sync_fifo_stream_reader #(.DATA_WIDTH(32), .FWFT(1'b0)) u_b (
    .clk_i(clk), .rst_i(rst), .bus(ifb.master)
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
    , .xfer_cnt_o(xb), .stall_cnt_o(sb)
`endif
  );

  // FIFO models: a is show-ahead, b returns data one cycle after the read
  logic [31:0] mema [64];
  logic [31:0] memb [64];
  int wra = 0, rda = 0, wrb = 0, rdb = 0;
  logic [31:0] rdb_q = 32'h0;

  assign ifa.fifo_empty_i   = (rda == wra);
  assign ifa.fifo_rd_data_i = mema[rda];
  assign ifb.fifo_empty_i   = (rdb == wrb);
  assign ifb.fifo_rd_data_i = rdb_q;

  always @(posedge clk) begin
    if (ifa.fifo_read_o) rda <= rda + 1;
    if (ifb.fifo_read_o) begin
      rdb_q <= memb[rdb];
      rdb   <= rdb + 1;
    end
  end

  logic [31:0] eqa [$];
  logic [31:0] eqb [$];
  int n_cmp = 0, n_bad = 0;
  int rca = 0, rcb = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // Monitor: transfers, hold stability, reads while empty, read counts
  logic        hold_a = 1'b0, hold_b = 1'b0;
  logic [31:0] hold_da, hold_db;
  always @(negedge clk) begin
    if (ifa.m_valid_o && ifa.m_ready_i) begin
      if (eqa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL a_unexpected: got %h want none", ifa.m_data_o);
      end else check("a_data", ifa.m_data_o, eqa.pop_front());
    end
    if (ifb.m_valid_o && ifb.m_ready_i) begin
      if (eqb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL b_unexpected: got %h want none", ifb.m_data_o);
      end else check("b_data", ifb.m_data_o, eqb.pop_front());
    end
    if (hold_a && !rst) begin
      check("a_hold_vld", 32'(ifa.m_valid_o), 32'd1);
      check("a_hold_data", ifa.m_data_o, hold_da);
    end
    if (hold_b && !rst) begin
      check("b_hold_vld", 32'(ifb.m_valid_o), 32'd1);
      check("b_hold_data", ifb.m_data_o, hold_db);
    end
    hold_a  = ifa.m_valid_o && !ifa.m_ready_i && !rst && !ifa.flush_i;
    hold_b  = ifb.m_valid_o && !ifb.m_ready_i && !rst && !ifb.flush_i;
    hold_da = ifa.m_data_o;
    hold_db = ifb.m_data_o;
    if (ifa.fifo_empty_i) check("a_rd_empty", 32'(ifa.fifo_read_o), 32'd0);
    if (ifb.fifo_empty_i) check("b_rd_empty", 32'(ifb.fifo_read_o), 32'd0);
    if (ifa.fifo_read_o) rca++;
    if (ifb.fifo_read_o) rcb++;
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
    #1;
  endtask

  task automatic push_a(input logic [31:0] w, input bit exp);
    mema[wra] = w; wra++;
    if (exp) eqa.push_back(w);
  endtask

  task automatic push_b(input logic [31:0] w, input bit exp);
    memb[wrb] = w; wrb++;
    if (exp) eqb.push_back(w);
  endtask

  task automatic chk_vld(input string name, input logic va, input logic vb);
    check({name, "_va"}, 32'(ifa.m_valid_o), 32'(va));
    check({name, "_vb"}, 32'(ifb.m_valid_o), 32'(vb));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  int r0a, r0b;
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
  logic [31:0] x0, s0;
`endif

  initial begin
    rst = 1'b1;
    ifa.m_ready_i = 1'b0; ifa.flush_i = 1'b0;
    ifb.m_ready_i = 1'b0; ifb.flush_i = 1'b0;
    cyc(2); smp;
    check("rst_va", 32'(ifa.m_valid_o), 0); check("rst_da", ifa.m_data_o, 0);
    check("rst_ra", 32'(ifa.fifo_read_o), 0);
    check("rst_vb", 32'(ifb.m_valid_o), 0); check("rst_db", ifb.m_data_o, 0);
    check("rst_rb", 32'(ifb.fifo_read_o), 0);
    cyc(1); rst = 1'b0;
    cyc(1);

    // Latency and streaming: a is valid 1 cycle after the read, b 2 cycles after
    ifa.m_ready_i = 1'b1; ifb.m_ready_i = 1'b1;
    r0a = rca; r0b = rcb;
    foreach (mema[i]) if (i < 3) begin push_a(32'hA1 + 32'(i), 1'b1); push_b(32'hA1 + 32'(i), 1'b1); end
    smp;
    check("t1_first_rd_a", 32'(ifa.fifo_read_o), 1);
    check("t1_first_rd_b", 32'(ifb.fifo_read_o), 1);
    chk_vld("t1_c0", 1'b0, 1'b0);
    cyc(1); smp; chk_vld("t1_c1", 1'b1, 1'b0);
    cyc(1); smp; chk_vld("t1_c2", 1'b1, 1'b1);
    cyc(1); smp; chk_vld("t1_c3", 1'b1, 1'b1);
    cyc(1); smp; chk_vld("t1_c4", 1'b0, 1'b1);
    cyc(1); smp; chk_vld("t1_c5", 1'b0, 1'b0);
    check("t1_reads_a", 32'(rca - r0a), 3);
    check("t1_reads_b", 32'(rcb - r0b), 3);

    // Backpressure: only two reads while stalled, head word held
    cyc(1);
    ifa.m_ready_i = 1'b0; ifb.m_ready_i = 1'b0;
    r0a = rca; r0b = rcb;
    foreach (mema[i]) if (i < 5) begin push_a(32'hB1 + 32'(i), 1'b1); push_b(32'hB1 + 32'(i), 1'b1); end
    cyc(6); smp;
    check("t2_reads_a", 32'(rca - r0a), 2);
    check("t2_reads_b", 32'(rcb - r0b), 2);
    check("t2_head_a", ifa.m_data_o, 32'hB1);
    check("t2_head_b", ifb.m_data_o, 32'hB1);
    chk_vld("t2_hold", 1'b1, 1'b1);
    cyc(1);
    ifa.m_ready_i = 1'b1; ifb.m_ready_i = 1'b1;
    cyc(10); smp;
    check("t2_drain_a", 32'(eqa.size()), 0);
    check("t2_drain_b", 32'(eqb.size()), 0);

    // Flush on b one cycle after a read: 0xC1 is in flight and gets dropped
    cyc(1);
    push_b(32'hC1, 1'b0); push_b(32'hC2, 1'b1); push_b(32'hC3, 1'b1);
    smp; check("t3_rd", 32'(ifb.fifo_read_o), 1);
    cyc(1); ifb.flush_i = 1'b1;
    smp; check("t3_no_rd_flush", 32'(ifb.fifo_read_o), 0);
    cyc(1); ifb.flush_i = 1'b0;
    smp; check("t3_vld_after", 32'(ifb.m_valid_o), 0);
    cyc(8); smp;
    check("t3_drain_b", 32'(eqb.size()), 0);

    // Reset with two words buffered and ready high; D3 stays in the FIFO
    cyc(1);
    ifa.m_ready_i = 1'b0; ifb.m_ready_i = 1'b0;
    r0a = rca; r0b = rcb;
    push_a(32'hD1, 1'b0); push_a(32'hD2, 1'b0); push_a(32'hD3, 1'b1);
    push_b(32'hD1, 1'b0); push_b(32'hD2, 1'b0); push_b(32'hD3, 1'b1);
    cyc(4); smp;
    check("t4_buf_a", ifa.m_data_o, 32'hD1);
    check("t4_buf_b", ifb.m_data_o, 32'hD1);
    cyc(1);
    rst = 1'b1; ifa.m_ready_i = 1'b1; ifb.m_ready_i = 1'b1;
    cyc(1); smp;
    chk_vld("t4_rst", 1'b0, 1'b0);
    check("t4_rst_da", ifa.m_data_o, 0); check("t4_rst_db", ifb.m_data_o, 0);
    check("t4_rst_ra", 32'(ifa.fifo_read_o), 0);
    check("t4_rst_rb", 32'(ifb.fifo_read_o), 0);
    cyc(1); rst = 1'b0;
    cyc(8); smp;
    check("t4_drain_a", 32'(eqa.size()), 0);
    check("t4_drain_b", 32'(eqb.size()), 0);
    check("t4_reads_a", 32'(rca - r0a), 3);
    check("t4_reads_b", 32'(rcb - r0b), 3);

    // Stats on a: 3 stall cycles then 4 pops; a later flush leaves counts alone
    cyc(1);
    ifa.m_ready_i = 1'b0;
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
    x0 = xa; s0 = sa;
`endif
    foreach (mema[i]) if (i < 4) push_a(32'hE1 + 32'(i), 1'b1);
    cyc(4); ifa.m_ready_i = 1'b1;
    cyc(6); smp;
    check("t5_drain_a", 32'(eqa.size()), 0);
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
    check("t5_xfer", xa - x0, 32'd4);
    check("t5_stall", sa - s0, 32'd3);
    x0 = xa; s0 = sa;
`endif
    cyc(1); ifa.flush_i = 1'b1;
    cyc(1); ifa.flush_i = 1'b0;
    cyc(2); smp;
`ifdef SYNC_FIFO_STREAM_READER_STATS_EN
    check("t5_xfer_flush", xa, x0);
    check("t5_stall_flush", sa, s0);
`endif
    check("t5_idle_va", 32'(ifa.m_valid_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
